// File: rtl/debug_view_pkg.sv
// Shared types for the debug hex viewer.
//   dv_mode_t       : display mode encoding on the 2-bit mode input
//   DV_BLANK_NIBBLE : nibble value driven on any blanked digit
package debug_view_pkg;

  typedef enum logic [1:0] {
    DV_LIVE    = 2'b00,
    DV_CAPTURE = 2'b01,
    DV_FREEZE  = 2'b10,
    DV_RSVD    = 2'b11
  } dv_mode_t;

  localparam logic [3:0] DV_BLANK_NIBBLE = 4'h0;

endpackage

// File: rtl/debug_page_timer.sv
// Page counter for the debug hex viewer.
// Advances the page on a page_step rising edge or on auto-scroll timer
// expiry (at most one step per cycle), wraps at PAGES-1, and is forced
// back to page 0 by clear.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   auto_scroll  : enables the scroll timer; timer held at 0 when low
//   page_step    : manual advance, level input, rising edge used
//   clear        : force page and timer to 0, beats any advance
//   page         : current page
module debug_page_timer #(
  parameter int unsigned SCROLL_DIV = 25000000,
  parameter int unsigned PAGES      = 2,
  parameter int unsigned PAGE_W     = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              auto_scroll,
  input  logic              page_step,
  input  logic              clear,
  output logic [PAGE_W-1:0] page
);

  localparam int unsigned TMR_W = $clog2(SCROLL_DIV);

  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [PAGE_W-1:0] page_nxt;
  logic              step_q;
  logic              advance;

  always_comb begin
    advance   = (page_step & ~step_q) |
                (auto_scroll && (timer == TMR_W'(SCROLL_DIV - 1)));
    page_nxt  = page;
    timer_nxt = timer;
    if (clear) begin
      page_nxt  = '0;
      timer_nxt = '0;
    end else begin
      if (!auto_scroll || advance)
        timer_nxt = '0;
      else
        timer_nxt = timer + TMR_W'(1);
      if (advance)
        page_nxt = (page == PAGE_W'(PAGES - 1)) ? '0 : page + PAGE_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      page   <= '0;
      timer  <= '0;
      step_q <= 1'b0;
    end else begin
      page   <= page_nxt;
      timer  <= timer_nxt;
      step_q <= page_step;
    end
  end

endmodule

// File: rtl/debug_hex_viewer.sv
// Debug display engine for the board hex digits.
// Selects one of NUM_CH debug words (live, captured-on-strobe or frozen),
// then slices the current page of nibbles onto NUM_DIGITS digits.
// Two register stages: word select, then page slice.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   ch_data      : NUM_CH packed live words, channel i at [i*CH_W +: CH_W]
//   ch_strobe    : per-channel capture strobe
//   sel          : displayed channel
//   mode         : 00 live, 01 capture, 10 freeze, 11 live
//   auto_scroll  : timed page advance enable
//   page_step    : manual page advance (rising edge)
//   hex_digits   : digit d nibble at [d*4 +: 4], digit 0 rightmost
//   digit_blank  : 1 = digit unused
//   page         : page currently shown
//   cap_valid    : channel has captured since reset
module debug_hex_viewer
  import debug_view_pkg::*;
#(
  parameter  int unsigned NUM_CH     = 8,
  parameter  int unsigned CH_W       = 32,
  parameter  int unsigned NUM_DIGITS = 6,
  parameter  int unsigned SCROLL_DIV = 25000000,
  localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned NIB        = CH_W / 4,
  localparam int unsigned PAGES      = (NIB + NUM_DIGITS - 1) / NUM_DIGITS,
  localparam int unsigned PAGE_W     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [NUM_CH*CH_W-1:0]  ch_data,
  input  logic [NUM_CH-1:0]       ch_strobe,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              mode,
  input  logic                    auto_scroll,
  input  logic                    page_step,
  output logic [NUM_DIGITS*4-1:0] hex_digits,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [PAGE_W-1:0]       page,
  output logic [NUM_CH-1:0]       cap_valid
);

  dv_mode_t mode_e;
  assign mode_e = dv_mode_t'(mode);

  logic [CH_W-1:0]         cap_q [NUM_CH];
  logic [CH_W-1:0]         live_word, cap_word;
  logic                    cap_ok;
  logic [CH_W-1:0]         s1_word, s1_word_nxt;
  logic                    s1_blank, s1_blank_nxt;
  logic [SEL_W-1:0]        sel_q;
  logic                    clear;
  logic [NUM_DIGITS*4-1:0] hex_nxt;
  logic [NUM_DIGITS-1:0]   blank_nxt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cap_q[i] <= '0;
      cap_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ch_strobe[i]) begin
          cap_q[i]     <= ch_data[i*CH_W +: CH_W];
          cap_valid[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    live_word = '0;
    cap_word  = '0;
    cap_ok    = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        live_word = ch_data[i*CH_W +: CH_W];
        cap_word  = cap_q[i];
        cap_ok    = cap_valid[i];
      end
    end
  end

  // Freeze is realised by stage 1 holding its own value, so the frozen
  // word is whatever stage 1 held when freeze was entered.
  always_comb begin
    s1_word_nxt  = s1_word;
    s1_blank_nxt = s1_blank;
    case (mode_e)
      DV_CAPTURE: begin
        s1_word_nxt  = cap_word;
        s1_blank_nxt = ~cap_ok;
      end
      DV_FREEZE: ;
      default: begin
        s1_word_nxt  = live_word;
        s1_blank_nxt = 1'b0;
      end
    endcase
  end

  assign clear = (sel != sel_q) && (mode_e != DV_FREEZE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_word  <= '0;
      s1_blank <= 1'b1;
      sel_q    <= '0;
    end else begin
      s1_word  <= s1_word_nxt;
      s1_blank <= s1_blank_nxt;
      sel_q    <= sel;
    end
  end

  debug_page_timer #(
    .SCROLL_DIV (SCROLL_DIV),
    .PAGES      (PAGES),
    .PAGE_W     (PAGE_W)
  ) u_page_timer (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .auto_scroll (auto_scroll),
    .page_step   (page_step),
    .clear       (clear),
    .page        (page)
  );

  always_comb begin
    int unsigned idx;
    idx       = 0;
    hex_nxt   = '0;
    blank_nxt = '1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      idx = 32'(page) * NUM_DIGITS + d;
      if (s1_blank || idx >= NIB) begin
        hex_nxt[d*4 +: 4] = DV_BLANK_NIBBLE;
        blank_nxt[d]      = 1'b1;
      end else begin
        hex_nxt[d*4 +: 4] = 4'(s1_word >> (idx * 4));
        blank_nxt[d]      = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hex_digits  <= '0;
      digit_blank <= '1;
    end else begin
      hex_digits  <= hex_nxt;
      digit_blank <= blank_nxt;
    end
  end

endmodule

// File: tb/tb_debug_hex_viewer.sv
// Self-checking bench for debug_hex_viewer (8 channels x 32 bits, 6 digits,
// SCROLL_DIV=4 so two pages and a short scroll period).
module tb_debug_hex_viewer;

  localparam int unsigned NUM_CH     = 8;
  localparam int unsigned CH_W       = 32;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned SCROLL_DIV = 4;

  logic                   Clk;
  logic                   Reset_n;
  logic [NUM_CH*CH_W-1:0] ch_data;
  logic [NUM_CH-1:0]      ch_strobe;
  logic [2:0]             sel;
  logic [1:0]             mode;
  logic                   auto_scroll;
  logic                   page_step;
  logic [23:0]            hex_digits;
  logic [5:0]             digit_blank;
  logic [0:0]             page;
  logic [7:0]             cap_valid;

  debug_hex_viewer #(
    .NUM_CH     (NUM_CH),
    .CH_W       (CH_W),
    .NUM_DIGITS (NUM_DIGITS),
    .SCROLL_DIV (SCROLL_DIV)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ch_data     (ch_data),
    .ch_strobe   (ch_strobe),
    .sel         (sel),
    .mode        (mode),
    .auto_scroll (auto_scroll),
    .page_step   (page_step),
    .hex_digits  (hex_digits),
    .digit_blank (digit_blank),
    .page        (page),
    .cap_valid   (cap_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [23:0] hex;
    logic [5:0]  blank;
    logic        pg;
    logic [7:0]  capv;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  sel;
    logic [31:0] word;
    logic [23:0] hex;
    logic [5:0]  blank;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[5];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] val);
    ch_data[ch*32 +: 32] = val;
  endtask

  task automatic sb_push(input string name, input logic [23:0] hex,
                         input logic [5:0] blank, input logic pg,
                         input logic [7:0] capv);
    exp_t e;
    e.name  = name;
    e.hex   = hex;
    e.blank = blank;
    e.pg    = pg;
    e.capv  = capv;
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty: no expected entry queued");
      return;
    end
    e = sbq.pop_front();
    if ({hex_digits, digit_blank, page, cap_valid} !==
        {e.hex, e.blank, e.pg, e.capv}) begin
      n_err++;
      $display("FAIL %s: got hex=%h blank=%b page=%0d capv=%h, want hex=%h blank=%b page=%0d capv=%h",
               e.name, hex_digits, digit_blank, page, cap_valid,
               e.hex, e.blank, e.pg, e.capv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b00, 3'd2, 32'h1234_5678, 24'h345678, 6'h00};
    vecs[1] = '{2'b00, 3'd0, 32'hFFFF_FFFF, 24'hFFFFFF, 6'h00};
    vecs[2] = '{2'b11, 3'd7, 32'h0A0B_0C0D, 24'h0B0C0D, 6'h00};
    vecs[3] = '{2'b01, 3'd5, 32'h00AB_CDEF, 24'h000000, 6'h3F};
    vecs[4] = '{2'b00, 3'd2, 32'h1234_5678, 24'h345678, 6'h00};

    Reset_n = 1'b1; ch_data = '0; ch_strobe = '0; sel = '0; mode = 2'b00;
    auto_scroll = 1'b0; page_step = 1'b0;
    #1 Reset_n = 1'b0;
    tick(2);
    sb_push("reset", 24'h0, 6'h3F, 1'b0, 8'h00);
    sb_check();
    Reset_n = 1'b1;

    // Live/reserved/capture-empty vectors, two-edge latency each.
    for (int i = 0; i < 5; i++) begin
      set_ch(int'(vecs[i].sel), vecs[i].word);
      sel  = vecs[i].sel;
      mode = vecs[i].mode;
      sb_push($sformatf("vec%0d", i), vecs[i].hex, vecs[i].blank, 1'b0, 8'h00);
      tick(2);
      sb_check();
    end

    // Manual paging and wrap.
    page_step = 1'b1;
    sb_push("step1_page", 24'h345678, 6'h00, 1'b1, 8'h00);
    tick(1); sb_check();
    sb_push("step1_digits", 24'h000012, 6'h3C, 1'b1, 8'h00);
    tick(1); sb_check();
    page_step = 1'b0; tick(1);
    page_step = 1'b1;
    sb_push("step_wrap", 24'h345678, 6'h00, 1'b0, 8'h00);
    tick(2); sb_check();
    page_step = 1'b0;

    // Auto scroll every 4 cycles.
    auto_scroll = 1'b1;
    sb_push("auto_pre", 24'h345678, 6'h00, 1'b0, 8'h00);
    tick(3); sb_check();
    sb_push("auto_adv1", 24'h345678, 6'h00, 1'b1, 8'h00);
    tick(1); sb_check();
    sb_push("auto_hold1", 24'h000012, 6'h3C, 1'b1, 8'h00);
    tick(3); sb_check();
    sb_push("auto_adv2", 24'h000012, 6'h3C, 1'b0, 8'h00);
    tick(1); sb_check();
    tick(3);
    page_step = 1'b1;  // rising edge lands on timer expiry
    sb_push("coincident", 24'h345678, 6'h00, 1'b1, 8'h00);
    tick(1); sb_check();
    page_step = 1'b0;
    sb_push("coinc_hold", 24'h000012, 6'h3C, 1'b1, 8'h00);
    tick(3); sb_check();
    sb_push("coinc_next", 24'h000012, 6'h3C, 1'b0, 8'h00);
    tick(1); sb_check();
    auto_scroll = 1'b0;
    sb_push("auto_off", 24'h345678, 6'h00, 1'b0, 8'h00);
    tick(6); sb_check();

    // sel change beats a simultaneous step.
    set_ch(1, 32'h0000_0000);
    sel = 3'd1; page_step = 1'b1;
    sb_push("sel_clear", 24'h345678, 6'h00, 1'b0, 8'h00);
    tick(1); sb_check();
    page_step = 1'b0;
    sel = 3'd2;
    tick(2);

    // Capture mode.
    mode = 2'b01; sel = 3'd5;
    sb_push("cap_empty", 24'h0, 6'h3F, 1'b0, 8'h00);
    tick(2); sb_check();
    set_ch(5, 32'h00AB_CDEF); ch_strobe = 8'h20;
    sb_push("cap_edge", 24'h0, 6'h3F, 1'b0, 8'h20);
    tick(1); sb_check();
    ch_strobe = 8'h00;
    sb_push("cap_show", 24'hABCDEF, 6'h00, 1'b0, 8'h20);
    tick(2); sb_check();
    set_ch(5, 32'h1111_1111); set_ch(1, 32'hCAFE_F00D); ch_strobe = 8'h02;
    tick(1);
    ch_strobe = 8'h00;
    sb_push("cap_stable", 24'hABCDEF, 6'h00, 1'b0, 8'h22);
    tick(2); sb_check();
    set_ch(5, 32'h0000_0011); ch_strobe = 8'h20;
    tick(1);
    set_ch(5, 32'h00B2_B2B2);
    tick(1);
    ch_strobe = 8'h00; set_ch(5, 32'h0077_7777);
    sb_push("cap_held", 24'hB2B2B2, 6'h00, 1'b0, 8'h22);
    tick(2); sb_check();

    // Freeze.
    mode = 2'b00; sel = 3'd3; set_ch(3, 32'hDEAD_BEEF);
    sb_push("frz_live", 24'hADBEEF, 6'h00, 1'b0, 8'h22);
    tick(2); sb_check();
    mode = 2'b10;
    tick(1);
    set_ch(3, 32'h0); set_ch(4, 32'h1212_1212); sel = 3'd4;
    sb_push("frz_hold", 24'hADBEEF, 6'h00, 1'b0, 8'h22);
    tick(3); sb_check();
    page_step = 1'b1;
    tick(1);
    page_step = 1'b0;
    sb_push("frz_page1", 24'h0000DE, 6'h3C, 1'b1, 8'h22);
    tick(1); sb_check();
    page_step = 1'b1;
    tick(1);
    page_step = 1'b0;
    mode = 2'b00;
    sb_push("frz_exit", 24'h121212, 6'h00, 1'b0, 8'h22);
    tick(2); sb_check();

    // Asynchronous reset mid-scroll.
    sel = 3'd2; tick(2);
    auto_scroll = 1'b1;
    sb_push("pre_reset", 24'h345678, 6'h00, 1'b1, 8'h22);
    tick(4); sb_check();
    #2 Reset_n = 1'b0;
    #1;
    sb_push("async_reset", 24'h0, 6'h3F, 1'b0, 8'h00);
    sb_check();
    auto_scroll = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    sb_push("post_reset", 24'h345678, 6'h00, 1'b0, 8'h00);
    tick(2); sb_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
